// File: rtl/mont_exp_ctrl_if.sv
// Bus between the exponentiation controller and the Montgomery multiplier.
// The controller is the master: it issues operands and start, the multiplier answers.
interface mont_exp_ctrl_if #(
   parameter int WIDTH = 1024
);
   logic             mm_start;
   logic [WIDTH-1:0] mm_a;
   logic [WIDTH-1:0] mm_b;
   logic [WIDTH-1:0] mm_m;
   logic [WIDTH-1:0] mm_result;
   logic             mm_done;

   modport master (
      output mm_start, mm_a, mm_b, mm_m,
      input  mm_result, mm_done
   );

   modport slave (
      input  mm_start, mm_a, mm_b, mm_m,
      output mm_result, mm_done
   );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery domain,
// sequencing an external Montgomery multiplier and finishing with a multiply-by-1.
module mont_exp_ctrl #(
   parameter int WIDTH     = 1024,
   parameter int EXP_WIDTH = 1024,
   parameter int LEN_WIDTH = 11
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_r,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [EXP_WIDTH-1:0] in_e,
   input  logic [LEN_WIDTH-1:0] in_e_len,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   mont_exp_ctrl_if.master      mm
);

   localparam logic [3:0] IDLE        = 4'd0;
   localparam logic [3:0] SQ_START    = 4'd1;
   localparam logic [3:0] SQ_WAIT     = 4'd2;
   localparam logic [3:0] MUL_START   = 4'd3;
   localparam logic [3:0] MUL_WAIT    = 4'd4;
   localparam logic [3:0] NEXT        = 4'd5;
   localparam logic [3:0] FINAL_START = 4'd6;
   localparam logic [3:0] FINAL_WAIT  = 4'd7;
   localparam logic [3:0] DONE        = 4'd8;

   logic [3:0]           state;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     x_reg;
   logic [WIDTH-1:0]     m_reg;
   logic [EXP_WIDTH-1:0] e_reg;
   logic [EXP_WIDTH-1:0] e_shifted;
   logic [LEN_WIDTH-1:0] i_reg;
   logic [LEN_WIDTH-1:0] len_clamped;
   logic                 cur_bit;

   // Lengths beyond the exponent register are clamped so i never points past e.
   always_comb begin
      len_clamped = in_e_len;
      if (int'(in_e_len) > EXP_WIDTH) begin
         len_clamped = LEN_WIDTH'(EXP_WIDTH);
      end
   end

   assign e_shifted = e_reg >> i_reg;
   assign cur_bit   = e_shifted[0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         a_reg  <= '0;
         x_reg  <= '0;
         m_reg  <= '0;
         e_reg  <= '0;
         i_reg  <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_reg <= in_x;
                  m_reg <= in_m;
                  e_reg <= in_e;
                  a_reg <= in_r;
                  i_reg <= len_clamped - LEN_WIDTH'(1);
                  state <= (len_clamped == '0) ? FINAL_START : SQ_START;
               end
            end
            SQ_START: state <= SQ_WAIT;
            SQ_WAIT: begin
               if (mm.mm_done) begin
                  a_reg <= mm.mm_result;
                  state <= cur_bit ? MUL_START : NEXT;
               end
            end
            MUL_START: state <= MUL_WAIT;
            MUL_WAIT: begin
               if (mm.mm_done) begin
                  a_reg <= mm.mm_result;
                  state <= NEXT;
               end
            end
            NEXT: begin
               if (i_reg == '0) begin
                  state <= FINAL_START;
               end else begin
                  i_reg <= i_reg - LEN_WIDTH'(1);
                  state <= SQ_START;
               end
            end
            FINAL_START: state <= FINAL_WAIT;
            FINAL_WAIT: begin
               if (mm.mm_done) begin
                  result <= mm.mm_result;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

   // Operands are decoded from the state so they hold from START through the matching WAIT.
   always_comb begin
      mm.mm_start = 1'b0;
      mm.mm_a     = '0;
      mm.mm_b     = '0;
      case (state)
         SQ_START, SQ_WAIT: begin
            mm.mm_start = (state == SQ_START);
            mm.mm_a     = a_reg;
            mm.mm_b     = a_reg;
         end
         MUL_START, MUL_WAIT: begin
            mm.mm_start = (state == MUL_START);
            mm.mm_a     = a_reg;
            mm.mm_b     = x_reg;
         end
         FINAL_START, FINAL_WAIT: begin
            mm.mm_start = (state == FINAL_START);
            mm.mm_a     = a_reg;
            mm.mm_b     = WIDTH'(1);
         end
         default: ;
      endcase
   end

   assign mm.mm_m = m_reg;

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
Modular exponentiation controller that sits directly upstream of the montgomery multiplier and drives its start/in_a/in_b/in_m inputs. It consumes the multiplier's result/done outputs. It computes x^e mod M by left-to-right binary square-and-multiply in the Montgomery domain, then does a final multiply-by-1 to leave the domain. Software supplies x~ = x·R mod M and R mod M, where R = 2^WIDTH.

Parameters:
WIDTH, 1024, operand/modulus width; must match the montgomery instance
EXP_WIDTH, 1024, exponent register width
LEN_WIDTH, 11, width of the exponent bit-length input

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
in_x  in  WIDTH  x~ = x·R mod M
in_r  in  WIDTH  R mod M (Montgomery one)
in_m  in  WIDTH  modulus M, odd, M > 1
in_e  in  EXP_WIDTH  exponent
in_e_len  in  LEN_WIDTH  number of exponent bits to process (t)
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse; result valid
result  out  WIDTH  x^e mod M; held until next accepted start
mm_start  out  1  one-cycle pulse to montgomery.start
mm_a  out  WIDTH  to montgomery.in_a
mm_b  out  WIDTH  to montgomery.in_b
mm_m  out  WIDTH  to montgomery.in_m
mm_result  in  WIDTH  from montgomery.result
mm_done  in  1  from montgomery.done; treated as a pulse, sampled only in WAIT states

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy, done and mm_start = 0; result, mm_a, mm_b, mm_m and all internal registers = 0. Reset mid-operation aborts immediately. Any later mm_done from the multiplier is ignored, because the controller is in IDLE.
- MM(a,b) denotes a·b·R^-1 mod M as produced by the multiplier.
- IDLE: on start=1, latch in_x, in_m and in_e, and load A<=in_r. Set i <= min(in_e_len, EXP_WIDTH) - 1. Set busy=1. If the clamped length is 0, go to FINAL_START; otherwise go to SQ_START.
- SQ_START: mm_a=A, mm_b=A, mm_m=M; mm_start=1 for exactly this cycle; next state is SQ_WAIT.
- SQ_WAIT: on mm_done, A<=mm_result. Then go to MUL_START if e[i]=1, else to NEXT.
- MUL_START: mm_a=A, mm_b=x~; mm_start pulse; next state is MUL_WAIT.
- MUL_WAIT: on mm_done, A<=mm_result; go to NEXT.
- NEXT: if i==0, go to FINAL_START; else i<=i-1 and go to SQ_START.
- FINAL_START: mm_a=A, mm_b=1 (zero-extended); mm_start pulse; next state is FINAL_WAIT.
- FINAL_WAIT: on mm_done, result<=mm_result; go to DONE.
- DONE: done=1 for one cycle, busy=0; return to IDLE. A new start can be accepted on the following cycle.
- mm_a, mm_b and mm_m stay stable from the START state through the end of the matching WAIT state.
- start while busy is ignored: no relatch, no effect on the in-flight operation.
- Multiply count for length t with k one-bits among e[t-1:0]: t squarings + k multiplies + 1 final. Exactly that many mm_start pulses occur.
- Total latency = count × (multiplier latency + 2) + t + 2 cycles, with ±1 allowed only for the DONE cycle; the bench checks the pulse count exactly.
- Exponent bits at or above in_e_len are never examined.

Test Plan:
- Use WIDTH=8 with a behavioural MM model in the bench (R=256). M=13, in_r=9, in_x=5 (x=2), in_e=5, in_e_len=3 -> result=6, exactly 6 mm_start pulses, single done pulse, busy low afterwards.
- WIDTH=8, M=13, in_r=9, in_x=0x27 (39 mod 13 = 0? no: x=3 gives x~=768 mod 13=1), so in_x=1, in_e=13, in_e_len=4 -> result=3, 8 mm_start pulses.
- in_e_len=0 -> result=1, exactly 1 mm_start; in_e=0 with in_e_len=3 -> result=1, 4 pulses.
- Assert start repeatedly during an operation with different in_x -> result unchanged from the single-start run; pulse count unchanged.
- Drop resetn mid-SQ_WAIT -> busy, done and mm_start are 0 immediately. A late mm_done produces no done. A fresh start then gives the correct result.
- Full WIDTH=1024 with the real montgomery instance: in_x = MM-form of 1 (in_x=in_r) and arbitrary e -> result=1. Check mm_m equals in_m throughout.
